// File: rtl/stuck_pkg.sv
// Shared types and constants for the stuck-at BIST controller and its MISR.
package stuck_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // Number of exhaustive vectors applied to an n_in-input circuit.
    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/stuck_misr.sv
// Multiple-input signature register: one response bit absorbed per enabled cycle.
module stuck_misr
    import stuck_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             d_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic d);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, d};
    endfunction

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = misr_step(sig_q, d_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/stuck_bist_ctrl.sv
// Exhaustive-pattern BIST controller for ckt: counts through all input vectors,
// compacts y into a MISR and flags pass/fail. STUCK_RAW_CAPTURE_EN adds resp_raw.
module stuck_bist_ctrl
    import stuck_pkg::*;
#(
    parameter int               N_IN   = 6,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] GOLDEN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic [N_IN-1:0]  vec_out,
    output logic             vec_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
`ifdef STUCK_RAW_CAPTURE_EN
    ,
    output logic [(1 << N_IN)-1:0] resp_raw
`endif
);

    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(vec_count(N_IN) - 1);

    state_e          state_q;
    state_e          state_d;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] vec_d;
    logic            load;
    logic            run;

    assign run = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        load    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // Natural wrap of the counter returns vec_out to 0 after the last vector.
                vec_d = vec_q + 1'b1;
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    stuck_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (run),
        .d_in (y_in),
        .sig  (signature)
    );

`ifdef STUCK_RAW_CAPTURE_EN
    logic [(1 << N_IN)-1:0] raw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q <= '0;
        end else if (load) begin
            raw_q <= '0;
        end else if (run) begin
            raw_q[vec_q] <= y_in;
        end
    end

    assign resp_raw = raw_q;
`endif

    assign vec_out   = vec_q;
    assign vec_valid = run;
    assign busy      = run;
    assign done      = (state_q == DONE);
    assign pass      = done && (signature == GOLDEN);

endmodule

// File: tb/tb_stuck_bist_ctrl.sv
// Self-checking bench for stuck_bist_ctrl: behavioural model on a 6-input instance,
// literal sequences on a 2-input instance. Honours STUCK_RAW_CAPTURE_EN.
module tb_stuck_bist_ctrl;

    localparam logic [15:0] POLY = 16'h1021;

    // Reference ckt: y = (x1 & x2) | ((x3 ^ x4) & ~(x5 & x6)); w1 = x1 & x2.
    function automatic logic ckt_f(input logic [5:0] x, input logic w1_sa0);
        logic w1;
        logic w2;
        logic w3;
        w1 = w1_sa0 ? 1'b0 : (x[5] & x[4]);
        w2 = x[3] ^ x[2];
        w3 = ~(x[1] & x[0]);
        return w1 | (w2 & w3);
    endfunction

    function automatic logic [15:0] misr_f(input logic [15:0] s, input logic y);
        int unsigned v;
        v = (32'(s) * 2) % 65536;
        if (s >= 16'h8000) v = v ^ 32'(POLY);
        return 16'(v ^ 32'(y));
    endfunction

    function automatic logic [15:0] golden_sig();
        logic [15:0] s;
        s = 16'h0000;
        for (int v = 0; v < 64; v++) s = misr_f(s, ckt_f(6'(v), 1'b0));
        return s;
    endfunction

    localparam logic [15:0] GOLD6 = golden_sig();

    logic        clk;
    logic        rst;
    logic        start6;
    logic        start2;
    int          mode6;
    int          mode2;
    logic        y_rnd;
    logic        y6;
    logic        y2;
    logic [5:0]  vec6;
    logic        vld6, busy6, done6, pass6;
    logic [15:0] sig6;
    logic [1:0]  vec2;
    logic        vld2, busy2, done2, pass2;
    logic [15:0] sig2;
`ifdef STUCK_RAW_CAPTURE_EN
    logic [63:0] raw6;
    logic [3:0]  raw2;
`endif

    int n_chk;
    int n_fail;
    bit chk_on;

    assign y6 = (mode6 == 0) ? y_rnd : ckt_f(vec6, mode6 == 2);
    assign y2 = (mode2 == 0) ? 1'b0 : (mode2 == 1) ? 1'b1 : vec2[0];

    stuck_bist_ctrl #(
        .N_IN(6), .SIG_W(16), .POLY(POLY), .SEED(16'h0000), .GOLDEN(GOLD6)
    ) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .y_in(y6),
        .vec_out(vec6), .vec_valid(vld6), .busy(busy6), .done(done6),
        .pass(pass6), .signature(sig6)
`ifdef STUCK_RAW_CAPTURE_EN
        , .resp_raw(raw6)
`endif
    );

    stuck_bist_ctrl #(
        .N_IN(2), .SIG_W(16), .POLY(POLY), .SEED(16'h0000), .GOLDEN(16'h0000)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .y_in(y2),
        .vec_out(vec2), .vec_valid(vld2), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2)
`ifdef STUCK_RAW_CAPTURE_EN
        , .resp_raw(raw2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        y_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #2 y_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model of the 6-input instance: phase 0 idle, 1 running, 2 finished.
    int          m_phase;
    int          m_idx;
    logic [15:0] m_sig;
    logic [63:0] m_raw;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_idx   <= 0;
            m_sig   <= 16'h0000;
            m_raw   <= '0;
        end else if (m_phase == 1) begin
            m_sig        <= misr_f(m_sig, y6);
            m_raw[m_idx] <= y6;
            if (m_idx == 63) begin
                m_phase <= 2;
                m_idx   <= 0;
            end else begin
                m_idx <= m_idx + 1;
            end
        end else if (start6) begin
            m_phase <= 1;
            m_idx   <= 0;
            m_sig   <= 16'h0000;
            m_raw   <= '0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_vec",   64'(vec6),  64'(m_idx));
            chk("m_valid", 64'(vld6),  64'(m_phase == 1));
            chk("m_busy",  64'(busy6), 64'(m_phase == 1));
            chk("m_done",  64'(done6), 64'(m_phase == 2));
            chk("m_sig",   64'(sig6),  64'(m_sig));
            chk("m_pass",  64'(pass6), 64'(m_phase == 2 && m_sig == GOLD6));
`ifdef STUCK_RAW_CAPTURE_EN
            chk("m_raw",   raw6,       m_raw);
`endif
        end
    end

    task automatic run6(input int s1, input int s2, output int len);
        @(posedge clk);
        #2 start6 = 1'b1;
        @(posedge clk);
        #2 start6 = 1'b0;
        len = 0;
        for (int c = 0; c < 300; c++) begin
            if (busy6) len++;
            if (done6) break;
            start6 = busy6 && (int'(vec6) == s1 || int'(vec6) == s2);
            @(posedge clk);
            #2;
        end
        start6 = 1'b0;
        chk("run6_done", 64'(done6), 64'd1);
    endtask

    task automatic run2(input int md, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3, input logic exp_pass);
        logic [15:0] e[4];
        e = '{e0, e1, e2, e3};
        mode2 = md;
        @(posedge clk);
        #2 start2 = 1'b1;
        @(posedge clk);
        #2 start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("n2_vec%0d", i), 64'(vec2), 64'(i));
            chk($sformatf("n2_vld%0d", i), 64'(vld2), 64'd1);
            @(posedge clk);
            #2;
            chk($sformatf("n2_sig%0d", i), 64'(sig2), 64'(e[i]));
        end
        chk("n2_done", 64'(done2), 64'd1);
        chk("n2_busy", 64'(busy2), 64'd0);
        chk("n2_vec_wrap", 64'(vec2), 64'd0);
        chk("n2_pass", 64'(pass2), 64'(exp_pass));
    endtask

    initial begin
        int          len;
        logic [15:0] s_ref;
        bit          hit;
        n_chk  = 0;
        n_fail = 0;
        chk_on = 1'b0;
        rst    = 1'b1;
        start6 = 1'b0;
        start2 = 1'b0;
        mode6  = 1;
        mode2  = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_vec",  64'(vec6),  64'd0);
        chk("rst_vld",  64'(vld6),  64'd0);
        chk("rst_busy", 64'(busy6), 64'd0);
        chk("rst_done", 64'(done6), 64'd0);
        chk("rst_pass", 64'(pass6), 64'd0);
        chk("rst_sig",  64'(sig6),  64'd0);
        rst    = 1'b0;
        chk_on = 1'b1;

        // Fault-free ckt, then a rerun from DONE.
        run6(-1, -1, len);
        chk("good_len", 64'(len), 64'd64);
        chk("good_pass", 64'(pass6), 64'd1);
        chk("good_sig", 64'(sig6), 64'(GOLD6));
        s_ref = sig6;
        run6(-1, -1, len);
        chk("rerun_sig", 64'(sig6), 64'(s_ref));
        chk("rerun_pass", 64'(pass6), 64'd1);

        // w1 stuck-at-0.
        mode6 = 2;
        run6(-1, -1, len);
        chk("fault_pass", 64'(pass6), 64'd0);
        chk("fault_sig_differs", 64'(sig6 != GOLD6), 64'd1);

        // Ignored starts during RUN, fault-free and random responses.
        mode6 = 1;
        run6(5, 40, len);
        chk("ign_len", 64'(len), 64'd64);
        chk("ign_sig", 64'(sig6), 64'(GOLD6));
        mode6 = 0;
        run6(5, 40, len);
        chk("rnd_len", 64'(len), 64'd64);
        run6(-1, -1, len);
        chk("rnd2_len", 64'(len), 64'd64);

        // Reset in the middle of a run.
        mode6 = 1;
        @(posedge clk);
        #2 start6 = 1'b1;
        @(posedge clk);
        #2 start6 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (vec6 == 6'd20) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("mid_reached20", 64'(hit), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_vec",  64'(vec6),  64'd0);
        chk("mid_vld",  64'(vld6),  64'd0);
        chk("mid_busy", 64'(busy6), 64'd0);
        chk("mid_done", 64'(done6), 64'd0);
        chk("mid_pass", 64'(pass6), 64'd0);
        chk("mid_sig",  64'(sig6),  64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        run6(-1, -1, len);
        chk("post_rst_len", 64'(len), 64'd64);
        chk("post_rst_sig", 64'(sig6), 64'(GOLD6));
        chk("post_rst_pass", 64'(pass6), 64'd1);

        // Two-input instance with fixed response patterns.
        run2(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        run2(1, 16'h0001, 16'h0003, 16'h0007, 16'h000F, 1'b0);
        run2(2, 16'h0000, 16'h0001, 16'h0002, 16'h0005, 1'b0);
`ifdef STUCK_RAW_CAPTURE_EN
        chk("n2_raw", 64'(raw2), 64'h0A);
`endif

        repeat (3) @(posedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
